tile_write_arbiter: RTL and testbench

Shares the single write port of the tile-map RAM (10-bit address, 4-bit tile code) between several sprite updaters (Pac-Man, ghosts). Each updater requests an atomic move: clear its old tile to background, then draw its sprite code at the new tile. A round-robin FSM serialises these moves so two sprites never interleave their writes. The block sits between the per-sprite behaviour logic and the tile RAM write port.

---
 rtl/tile_pkg.sv | 7 +
 rtl/rr_picker.sv | 24 ++
 rtl/tile_write_arbiter.sv | 129 ++++++++++++
 tb/tb_tile_write_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// tile_pkg: shared tile-map widths, background code and arbiter state encoding.
package tile_pkg;
    localparam int TILE_ADDR_W = 10;
    localparam int TILE_DATA_W = 4;
    localparam logic [TILE_DATA_W-1:0] TILE_BG = 4'b0000;
    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner select, search starts at ptr.
module rr_picker #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] win,
    output logic          vld
);
    int idx;

    // Walk offsets from farthest to nearest so the requester closest to ptr overwrites last.
    always_comb begin
        win = '0;
        idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx -= N;
            if (req[idx]) win = IW'(idx);
        end
        vld = |req;
    end
endmodule

// File: rtl/tile_write_arbiter.sv
// tile_write_arbiter: serialises clear/draw sprite moves onto the single tile RAM write port.
// Optional sprite overlap detection is built when TILE_ARB_COLLISION_EN is defined.
module tile_write_arbiter
    import tile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W = TILE_ADDR_W,
    parameter int DATA_W = TILE_DATA_W,
    parameter logic [DATA_W-1:0] BG_CODE = TILE_BG
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] old_addr,
    input  logic [NUM_REQ*ADDR_W-1:0] new_addr,
    input  logic [NUM_REQ*DATA_W-1:0] sprite_code,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic                      wren,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data,
    output logic                      collision,
    output logic [NUM_REQ-1:0]        collision_mask
);
    localparam int IW = $clog2(NUM_REQ);

    arb_state_t state, state_n;
    logic [IW-1:0] rr_ptr, win, lat_win;
    logic vld, take, wren_n;
    logic [ADDR_W-1:0] lat_old, lat_new, src_old, src_new, addr_n;
    logic [DATA_W-1:0] lat_code, src_code, data_n;
    logic [NUM_REQ-1:0] ack_n, win_oh;
    logic [ADDR_W-1:0] olds [NUM_REQ];
    logic [ADDR_W-1:0] news [NUM_REQ];
    logic [DATA_W-1:0] codes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign olds[i]  = old_addr[i*ADDR_W +: ADDR_W];
        assign news[i]  = new_addr[i*ADDR_W +: ADDR_W];
        assign codes[i] = sprite_code[i*DATA_W +: DATA_W];
    end

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req(req),
        .ptr(rr_ptr),
        .win(win),
        .vld(vld)
    );

    assign take   = state == IDLE && vld;
    assign win_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << lat_win;
    // Outputs are registered from the next state, so the grant cycle must use the live inputs.
    assign src_old  = take ? olds[win]  : lat_old;
    assign src_new  = take ? news[win]  : lat_new;
    assign src_code = take ? codes[win] : lat_code;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (take) state_n = olds[win] == news[win] ? DRAW : CLEAR;
            CLEAR:   state_n = DRAW;
            DRAW:    state_n = DONE;
            default: state_n = IDLE;
        endcase
        wren_n = state_n == CLEAR || state_n == DRAW;
        addr_n = state_n == CLEAR ? src_old : state_n == DRAW ? src_new : '0;
        data_n = state_n == DRAW ? src_code : state_n == CLEAR ? BG_CODE : '0;
        ack_n  = state_n == DONE ? win_oh : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            wren       <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            ack        <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            wren       <= wren_n;
            write_addr <= addr_n;
            write_data <= data_n;
            ack        <= ack_n;
            busy       <= state_n != IDLE;
            if (state == DONE) rr_ptr <= lat_win == IW'(NUM_REQ - 1) ? '0 : lat_win + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            lat_win  <= win;
            lat_old  <= olds[win];
            lat_new  <= news[win];
            lat_code <= codes[win];
        end
    end

`ifdef TILE_ARB_COLLISION_EN
    logic [ADDR_W-1:0] loc [NUM_REQ];
    logic [NUM_REQ-1:0] loc_vld, hit;

    always_comb begin
        hit = '0;
        for (int j = 0; j < NUM_REQ; j++)
            hit[j] = loc_vld[j] && loc[j] == lat_new && IW'(j) != lat_win;
    end

    // Compared against positions before this draw lands; the pulse appears in DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            loc_vld        <= '0;
            collision      <= 1'b0;
            collision_mask <= '0;
        end else begin
            collision      <= state == DRAW && |hit;
            collision_mask <= state == DRAW && |hit ? hit | win_oh : '0;
            if (state == DRAW) begin
                loc[lat_win]     <= lat_new;
                loc_vld[lat_win] <= 1'b1;
            end
        end
    end
`else
    assign collision      = 1'b0;
    assign collision_mask = '0;
`endif
endmodule

// File: tb/tb_tile_write_arbiter.sv
// tb_tile_write_arbiter: directed cycle-by-cycle checks of the tile write arbiter.
module tb_tile_write_arbiter;
    localparam int N = 4;
    localparam int AW = 10;
    localparam int DW = 4;
`ifdef TILE_ARB_COLLISION_EN
    localparam bit COL = 1'b1;
`else
    localparam bit COL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] req;
    logic [N*AW-1:0] old_addr, new_addr;
    logic [N*DW-1:0] sprite_code;
    logic [N-1:0] ack, collision_mask;
    logic busy, wren, collision;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    int n_cmp = 0;
    int n_bad = 0;
    int w;

    tile_write_arbiter dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .old_addr(old_addr),
        .new_addr(new_addr),
        .sprite_code(sprite_code),
        .ack(ack),
        .busy(busy),
        .wren(wren),
        .write_addr(write_addr),
        .write_data(write_data),
        .collision(collision),
        .collision_mask(collision_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input int i, input int o, input int n, input int c);
        old_addr[i*AW +: AW]    = AW'(o);
        new_addr[i*AW +: AW]    = AW'(n);
        sprite_code[i*DW +: DW] = DW'(c);
    endtask

    // Address/data are only meaningful while wren is high.
    task automatic port(input string tag, input logic we, input int a, input int d,
                        input logic [N-1:0] k, input logic b);
        check({tag, ".wren"}, wren, we);
        check({tag, ".ack"}, ack, k);
        check({tag, ".busy"}, busy, b);
        if (we) begin
            check({tag, ".addr"}, write_addr, a);
            check({tag, ".data"}, write_data, d);
        end
    endtask

    initial begin
        reset = 1'b0;
        req = '0;
        old_addr = '0;
        new_addr = '0;
        sprite_code = '0;
        tick;
        tick;
        port("rst", 0, 0, 0, 4'b0000, 0);
        check("rst.addr", write_addr, 0);
        check("rst.data", write_data, 0);
        check("rst.col", collision, 0);
        check("rst.mask", collision_mask, 0);
        reset = 1'b1;
        tick;

        slot(0, 33, 34, 3);
        req = 4'b0001;
        tick; port("one.clr", 1, 33, 0, 4'b0000, 1);
        tick; port("one.drw", 1, 34, 3, 4'b0000, 1);
        tick; port("one.ack", 0, 0, 0, 4'b0001, 1);
        req = '0;
        tick; port("one.idle", 0, 0, 0, 4'b0000, 0);

        slot(1, 100, 100, 5);
        req = 4'b0010;
        tick; port("eq.drw", 1, 100, 5, 4'b0000, 1);
        tick; port("eq.ack", 0, 0, 0, 4'b0010, 1);
        req = '0;
        tick; port("eq.idle", 0, 0, 0, 4'b0000, 0);

        reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        for (int i = 0; i < N; i++) slot(i, 10 + i, 20 + i, 8 + i);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = k % N;
            tick; port($sformatf("rr%0d.clr", k), 1, 10 + w, 0, 4'b0000, 1);
            tick; port($sformatf("rr%0d.drw", k), 1, 20 + w, 8 + w, 4'b0000, 1);
            tick;
            if (k == 4) req = '0;
            port($sformatf("rr%0d.ack", k), 0, 0, 0, 4'b0001 << w, 1);
            tick; port($sformatf("rr%0d.idle", k), 0, 0, 0, 4'b0000, 0);
        end

        req = 4'b0100;
        tick; port("mid.clr", 1, 12, 0, 4'b0000, 1);
        req = '0;
        slot(2, 12, 300, 10);
        tick; port("mid.drw", 1, 22, 10, 4'b0000, 1);
        tick; port("mid.ack", 0, 0, 0, 4'b0100, 1);
        tick; port("mid.idle", 0, 0, 0, 4'b0000, 0);
        slot(2, 12, 22, 10);

        req = 4'b1000;
        tick; port("rd.clr", 1, 13, 0, 4'b0000, 1);
        tick; port("rd.drw", 1, 23, 11, 4'b0000, 1);
        reset = 1'b0;
        req = '0;
        tick; port("rd.rst", 0, 0, 0, 4'b0000, 0);
        reset = 1'b1;
        tick; port("rd.noack", 0, 0, 0, 4'b0000, 0);
        req = 4'b1001;
        tick; port("rd.clr0", 1, 10, 0, 4'b0000, 1);
        tick; port("rd.drw0", 1, 20, 8, 4'b0000, 1);
        tick; port("rd.ack0", 0, 0, 0, 4'b0001, 1);
        req = '0;
        tick; port("rd.idle", 0, 0, 0, 4'b0000, 0);

        slot(1, 21, 200, 9);
        req = 4'b0010;
        tick; port("c1.clr", 1, 21, 0, 4'b0000, 1);
        tick; port("c1.drw", 1, 200, 9, 4'b0000, 1);
        tick; port("c1.ack", 0, 0, 0, 4'b0010, 1);
        check("c1.col", collision, 0);
        req = '0;
        tick; port("c1.idle", 0, 0, 0, 4'b0000, 0);
        slot(0, 20, 200, 8);
        req = 4'b0001;
        tick; port("c0.clr", 1, 20, 0, 4'b0000, 1);
        tick; port("c0.drw", 1, 200, 8, 4'b0000, 1);
        check("c0.col_early", collision, 0);
        tick; port("c0.ack", 0, 0, 0, 4'b0001, 1);
        check("c0.col", collision, COL);
        check("c0.mask", collision_mask, COL ? 4'b0011 : 4'b0000);
        req = '0;
        tick; port("c0.idle", 0, 0, 0, 4'b0000, 0);
        check("c0.col_end", collision, 0);
        check("c0.mask_end", collision_mask, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
